// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: shared UART state encodings, oversample ratio, divisor fn. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int uart_divisor(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_if: request/line bundle between byte source and uart_tx.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_if;
  import uart_pkg::*;

  logic              i_tx_start;
  logic [DATA_W-1:0] i_data;
  logic              o_tx;
  logic              o_tx_done;
  logic              o_busy;

  modport master (
    output i_tx_start,
    output i_data,
    input  o_tx,
    input  o_tx_done,
    input  o_busy
  );

  modport slave (
    input  i_tx_start,
    input  i_data,
    output o_tx,
    output o_tx_done,
    output o_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_gen: free-running 16x oversample tick, one clk wide.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19200
) (
  input  wire logic clk,
  input  wire logic rst,
  output logic      o_tick
);

  localparam int c_DIVISOR = uart_divisor(CLK_FREQ, BAUD);
  localparam int c_CW      = (c_DIVISOR > 1) ? $clog2(c_DIVISOR) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_DIVISOR - 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  assign o_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx: 8N1 serial transmitter, LSB first; 8E1 when UART_PARITY_EN  |
// | is defined. Rev 1.0                                                  |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19200,
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16
) (
  input  wire logic  clk,
  input  wire logic  rst,
  uart_tx_if.slave   bus
);

  localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [c_NW-1:0] c_NLAST   = c_NW'(DBIT - 1);
  localparam logic [3:0]      c_BITLAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      c_SBLAST  = 4'(SB_TICK - 1);

  logic            w_tick;
  uart_state_e     r_state;
  logic [3:0]      r_s_cnt;
  logic [c_NW-1:0] r_n_cnt;
  logic [DBIT-1:0] r_shreg;
  logic            r_tx;
  logic            r_done;
  logic            r_busy;
`ifdef UART_PARITY_EN
  logic            r_par;
`endif

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // Line level for each state is loaded on the transition edge so o_tx stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (bus.i_tx_start) begin
            r_shreg <= bus.i_data[DBIT-1:0];
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
            r_state <= ST_START;
`ifdef UART_PARITY_EN
            r_par   <= ^bus.i_data[DBIT-1:0];
`endif
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_s_cnt <= r_s_cnt + 4'd1;
            if (r_s_cnt == c_BITLAST) begin
              r_tx    <= r_shreg[0];
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_s_cnt <= r_s_cnt + 4'd1;
            if (r_s_cnt == c_BITLAST) begin
              r_shreg <= r_shreg >> 1;
              if (r_n_cnt == c_NLAST) begin
`ifdef UART_PARITY_EN
                r_tx    <= r_par;
                r_state <= ST_PARITY;
`else
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
`endif
              end else begin
                r_n_cnt <= r_n_cnt + c_NW'(1);
                r_tx    <= r_shreg[1];
              end
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_s_cnt <= r_s_cnt + 4'd1;
            if (r_s_cnt == c_BITLAST) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_s_cnt == c_SBLAST) begin
              r_s_cnt <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx      = r_tx;
  assign bus.o_tx_done = r_done;
  assign bus.o_busy    = r_busy;

endmodule
`default_nettype wire
